large_divider: RTL and testbench

Iterative restoring divider: the inverse of the registered large multiplier path. It takes a double-width dividend (e.g. a product from the multiplier wrapper) and a divisor, and returns the quotient and remainder after a fixed number of cycles. It sits beside the multiplier wrapper in the arithmetic datapath, uses the same operand widths, and has a start/busy/rdy handshake for sequencing.

---
 rtl/large_arith_pkg.sv | 22 ++
 rtl/large_divider_div_step.sv | 27 ++
 rtl/large_divider.sv | 191 +++++++++++++++++++
 tb/tb_large_divider.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/large_arith_pkg.sv
// Shared definitions for the large multiplier/divider arithmetic datapath:
// default operand widths, divider state encoding and iteration counter sizing.
package large_arith_pkg;

  localparam int INPUT1_WIDTH = 64;
  localparam int INPUT2_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    DONE
  } div_state_e;

  // Counter must be able to represent the full iteration count, hence the +1.
  function automatic int iter_cnt_width(input int w1);
    return $clog2(w1 + 1);
  endfunction

  localparam int ITER_CNT_WIDTH = iter_cnt_width(INPUT1_WIDTH);

endpackage

// File: rtl/large_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract
// the divisor when it fits, producing one quotient bit.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] r_shift;

  // The compare uses the full shifted value so the step stays correct even if
  // the incoming remainder ever had its top bit set.
  always_comb begin
    r_shift = {r_in, dividend_bit};
    q_bit   = (r_shift >= {2'b00, divisor});
    if (q_bit) begin
      r_out = r_shift[WIDTH:0] - {1'b0, divisor};
    end else begin
      r_out = r_shift[WIDTH:0];
    end
  end

endmodule

// File: rtl/large_divider.sv
// Iterative restoring divider (double-width dividend / single-width divisor).
// Optional LARGE_DIVIDER_OUTREG_EN adds one output register stage after DONE.
module large_divider #(
  parameter int INPUT1_WIDTH = large_arith_pkg::INPUT1_WIDTH,
  parameter int INPUT2_WIDTH = large_arith_pkg::INPUT2_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] dividend,
  input  logic [INPUT2_WIDTH-1:0]              divisor,
  output logic                                 busy,
  output logic                                 rdy,
  output logic [INPUT1_WIDTH-1:0]              quotient,
  output logic [INPUT2_WIDTH-1:0]              remainder,
  output logic                                 div_by_zero,
  output logic                                 overflow
);

  import large_arith_pkg::*;

  localparam int W1    = INPUT1_WIDTH;
  localparam int W2    = INPUT2_WIDTH;
  localparam int DW    = W1 + W2;
  localparam int CNT_W = iter_cnt_width(W1);

  div_state_e state_q, state_d;

  logic [DW-1:0]    dvd_q, dvd_d;
  logic [W2-1:0]    dvs_q, dvs_d;
  logic [W2:0]      r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W1-1:0] res_quot_q, res_quot_d;
  logic [W2-1:0] res_rem_q, res_rem_d;
  logic          res_dbz_q, res_dbz_d;
  logic          res_ovf_q, res_ovf_d;
  logic          res_rdy_q, res_rdy_d;

  logic [W2:0] step_r;
  logic        step_q;

  // The low half of the dividend register doubles as the quotient shift register.
  div_step #(
    .WIDTH(W2)
  ) u_div_step (
    .r_in        (r_q),
    .dividend_bit(dvd_q[W1-1]),
    .divisor     (dvs_q),
    .r_out       (step_r),
    .q_bit       (step_q)
  );

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
    res_dbz_d  = res_dbz_q;
    res_ovf_d  = res_ovf_q;
    res_rdy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (dvs_q == '0) begin
          res_quot_d = '1;
          res_rem_d  = dvd_q[W2-1:0];
          res_dbz_d  = 1'b1;
          res_ovf_d  = 1'b0;
          res_rdy_d  = 1'b1;
          state_d    = DONE;
        end else if (dvd_q[DW-1:W1] >= dvs_q) begin
          res_quot_d = '1;
          res_rem_d  = '0;
          res_dbz_d  = 1'b0;
          res_ovf_d  = 1'b1;
          res_rdy_d  = 1'b1;
          state_d    = DONE;
        end else begin
          r_d     = {1'b0, dvd_q[DW-1:W1]};
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        r_d             = step_r;
        dvd_d[W1-1:0]   = {dvd_q[W1-2:0], step_q};
        cnt_d           = cnt_q + CNT_W'(1);
        // Results are captured on the last step so they are valid in DONE.
        if (cnt_q == CNT_W'(W1 - 1)) begin
          res_quot_d = {dvd_q[W1-2:0], step_q};
          res_rem_d  = step_r[W2-1:0];
          res_dbz_d  = 1'b0;
          res_ovf_d  = 1'b0;
          res_rdy_d  = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
      res_dbz_q  <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
      res_dbz_q  <= res_dbz_d;
      res_ovf_q  <= res_ovf_d;
      res_rdy_q  <= res_rdy_d;
    end
  end

`ifdef LARGE_DIVIDER_OUTREG_EN
  logic [W1-1:0] out_quot_q, out_quot_d;
  logic [W2-1:0] out_rem_q, out_rem_d;
  logic          out_dbz_q, out_dbz_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_rdy_q, out_rdy_d;

  always_comb begin
    out_quot_d = res_quot_q;
    out_rem_d  = res_rem_q;
    out_dbz_d  = res_dbz_q;
    out_ovf_d  = res_ovf_q;
    out_rdy_d  = res_rdy_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_dbz_q  <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_rdy_q  <= 1'b0;
    end else begin
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      out_dbz_q  <= out_dbz_d;
      out_ovf_q  <= out_ovf_d;
      out_rdy_q  <= out_rdy_d;
    end
  end

  // The delayed rdy cycle still counts as busy so no new start slips in early.
  assign busy        = (state_q != IDLE) || out_rdy_q;
  assign rdy         = out_rdy_q;
  assign quotient    = out_quot_q;
  assign remainder   = out_rem_q;
  assign div_by_zero = out_dbz_q;
  assign overflow    = out_ovf_q;
`else
  assign busy        = (state_q != IDLE);
  assign rdy         = res_rdy_q;
  assign quotient    = res_quot_q;
  assign remainder   = res_rem_q;
  assign div_by_zero = res_dbz_q;
  assign overflow    = res_ovf_q;
`endif

endmodule

// File: tb/tb_large_divider.sv
// Self-checking bench for large_divider: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_large_divider;

  localparam int W1 = 64;
  localparam int W2 = 64;
`ifdef LARGE_DIVIDER_OUTREG_EN
  localparam int EXTRA_LAT = 1;
`else
  localparam int EXTRA_LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W1+W2-1:0] dividend = '0;
  logic [W2-1:0]  divisor = '0;
  logic           busy;
  logic           rdy;
  logic [W1-1:0]  quotient;
  logic [W2-1:0]  remainder;
  logic           div_by_zero;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  large_divider #(
    .INPUT1_WIDTH(W1),
    .INPUT2_WIDTH(W2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .rdy        (rdy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: integer division on the full-width values.
  function automatic void model(input logic [127:0] dvd, input logic [63:0] dvs,
                                output logic [63:0] q, output logic [63:0] r,
                                output bit dbz, output bit ovf, output int lat);
    logic [127:0] qq;
    logic [127:0] rr;
    dbz = 0;
    ovf = 0;
    if (dvs == 64'd0) begin
      dbz = 1;
      q   = '1;
      r   = dvd[63:0];
      lat = 2;
    end else begin
      qq = dvd / {64'd0, dvs};
      rr = dvd % {64'd0, dvs};
      if (qq[127:64] != 64'd0) begin
        ovf = 1;
        q   = '1;
        r   = '0;
        lat = 2;
      end else begin
        q   = qq[63:0];
        r   = rr[63:0];
        lat = W1 + 2;
      end
    end
    lat = lat + EXTRA_LAT;
  endfunction

  task automatic apply_stimulus(input logic [127:0] dvd, input logic [63:0] dvs,
                                output int lat, output bit busy_ok);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom, $urandom, $urandom};
    divisor  = {$urandom, $urandom};
    lat      = 1;
    busy_ok  = 1;
    while (!rdy && lat < 200) begin
      if (!busy) busy_ok = 0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!busy) busy_ok = 0;
  endtask

  task automatic run_and_check(input string tag, input logic [127:0] dvd, input logic [63:0] dvs);
    int lat;
    bit busy_ok;
    logic [63:0] eq;
    logic [63:0] er;
    bit edbz;
    bit eovf;
    int elat;
    model(dvd, dvs, eq, er, edbz, eovf, elat);
    apply_stimulus(dvd, dvs, lat, busy_ok);
    check_output({tag, ".latency"}, 128'(lat), 128'(elat));
    check_output({tag, ".quotient"}, 128'(quotient), 128'(eq));
    check_output({tag, ".remainder"}, 128'(remainder), 128'(er));
    check_output({tag, ".div_by_zero"}, 128'(div_by_zero), 128'(edbz));
    check_output({tag, ".overflow"}, 128'(overflow), 128'(eovf));
    check_output({tag, ".busy_span"}, 128'(busy_ok), 128'(1));
    @(posedge clk);
    #1;
    check_output({tag, ".rdy_pulse"}, 128'(rdy), 128'(0));
    check_output({tag, ".busy_after"}, 128'(busy), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".busy"}, 128'(busy), 128'(0));
    check_output({tag, ".rdy"}, 128'(rdy), 128'(0));
    check_output({tag, ".quotient"}, 128'(quotient), 128'(0));
    check_output({tag, ".remainder"}, 128'(remainder), 128'(0));
    check_output({tag, ".div_by_zero"}, 128'(div_by_zero), 128'(0));
    check_output({tag, ".overflow"}, 128'(overflow), 128'(0));
  endtask

  initial begin
    int rdy_cnt;
    logic [63:0] cap_q;
    logic [63:0] cap_r;
    logic [63:0] dvs;
    logic [127:0] dvd;
    int mode;

    $display("[TB] start");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_and_check("d100_7", 128'd100, 64'd7);
    check_output("d100_7.quot_const", 128'(quotient), 128'd14);
    check_output("d100_7.rem_const", 128'(remainder), 128'd2);

    run_and_check("max_product", 128'hFFFFFFFFFFFFFFFE_0000000000000001, 64'hFFFFFFFFFFFFFFFF);
    check_output("max_product.quot_const", 128'(quotient), 128'hFFFFFFFFFFFFFFFF);

    run_and_check("div_zero", 128'h1234, 64'd0);
    check_output("div_zero.rem_const", 128'(remainder), 128'h1234);

    run_and_check("ovf_2p64", 128'h0000000000000001_0000000000000000, 64'd1);

    dvs = 64'h8000000000000001;
    run_and_check("hi_eq_dvs_minus1", {dvs - 64'd1, 64'hFFFFFFFFFFFFFFFF}, dvs);
    run_and_check("hi_eq_dvs", {dvs, 64'd0}, dvs);

    // A start arriving mid-iteration must be dropped, not queued.
    @(negedge clk);
    dividend = 128'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    rdy_cnt = 0;
    cap_q   = '0;
    cap_r   = '0;
    for (int c = 1; c <= 90; c++) begin
      if (c == 10) begin
        start    = 1'b1;
        dividend = 128'd1000;
        divisor  = 64'd3;
      end
      if (c == 11) start = 1'b0;
      if (rdy) begin
        rdy_cnt++;
        cap_q = quotient;
        cap_r = remainder;
      end
      @(posedge clk);
      #1;
    end
    check_output("ignored_start.rdy_count", 128'(rdy_cnt), 128'd1);
    check_output("ignored_start.quotient", 128'(cap_q), 128'd14);
    check_output("ignored_start.remainder", 128'(cap_r), 128'd2);

    // Reset during iteration 30 aborts the operation silently.
    @(negedge clk);
    dividend = 128'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 31; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("rst_mid");
    rdy_cnt = 0;
    for (int c = 0; c < 90; c++) begin
      if (rdy) rdy_cnt++;
      @(posedge clk);
      #1;
    end
    check_output("rst_mid.no_rdy", 128'(rdy_cnt), 128'd0);
    run_and_check("after_rst_9_3", 128'd9, 64'd3);
    check_output("after_rst_9_3.quot_const", 128'(quotient), 128'd3);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 7);
      dvs  = {$urandom, $urandom};
      dvd  = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
        0: dvs = 64'd0;
        1: ;
        2: begin
          dvs = 64'($urandom_range(1, 1000));
          dvd = {96'd0, $urandom};
        end
        3: begin
          dvs = {32'd0, $urandom} | 64'd1;
          dvd[127:64] = dvd[127:64] % dvs;
        end
        default: begin
          if (dvs == 64'd0) dvs = 64'd1;
          dvd[127:64] = dvd[127:64] % dvs;
        end
      endcase
      run_and_check($sformatf("rnd%0d", i), dvd, dvs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
